// File: rtl/keypad_emulator_if.sv
// Keypad emulator bus: key-request handshake, row/column scan lines and status.
// master = request source and scanner side, slave = the emulated keypad.
//
// Handshake: key_in is taken when key_valid && key_ready are both high at a
// rising clk edge. key_ready is high only while the emulator is idle, and
// key_valid seen while it is busy is ignored, not queued.
interface keypad_emulator_if;
    logic [3:0] key_in;
    logic       key_valid;
    logic       key_ready;
    logic [3:0] row;
    logic [3:0] col;
    logic       busy;
    logic       done;
    logic [1:0] dbg_state;

    modport master (
        output key_in, key_valid, row,
        input  key_ready, col, busy, done, dbg_state
    );

    modport slave (
        input  key_in, key_valid, row,
        output key_ready, col, busy, done, dbg_state
    );
endinterface

// File: rtl/keypad_emulator.sv
// 4x4 matrix keypad emulator. A request presses one key for HOLD_TICKS cycles,
// then holds it released for GAP_TICKS cycles before the next request is taken.
// The pressed key pulls its column low whenever the scanner drives its row low.
// Optional feature: define KEYPAD_EMU_BOUNCE_EN to add LFSR-driven contact
// bounce over the first BOUNCE_TICKS cycles of both the press and the release.
module keypad_emulator #(
    parameter int HOLD_TICKS   = 1_000_000,
    parameter int GAP_TICKS    = 1_000_000,
    parameter int CNT_W        = 24,
    parameter int BOUNCE_TICKS = 2_000
) (
    input  logic               clk,
    input  logic               rst,
    keypad_emulator_if.slave   kp_bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESS   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);

    // Bounce window must fit inside both the press and the release phases.
    if (HOLD_TICKS < 1 || GAP_TICKS < 1 ||
        BOUNCE_TICKS >= HOLD_TICKS || BOUNCE_TICKS >= GAP_TICKS) begin : g_param_check
        $error("keypad_emulator: need BOUNCE_TICKS < min(HOLD_TICKS, GAP_TICKS)");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       r_key;
    logic [3:0]       w_key_nxt;
    logic [3:0]       r_col;
    logic [3:0]       w_col_nxt;
    logic             r_busy;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_pressed;
    logic [1:0]       w_row_idx;
    logic [1:0]       w_col_idx;

    // State, counter, latched key and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_key   <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_col   <= 4'hF;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_key   <= w_key_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= w_done_nxt;
            r_col   <= w_col_nxt;
        end
    end

    // Next state: accept in IDLE, count out the hold, then count out the gap.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_key_nxt   = r_key;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (kp_bus.key_valid) begin
                    w_key_nxt   = kp_bus.key_in;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_PRESS;
                end
            end
            S_PRESS: begin
                if (r_cnt == HOLD_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RELEASE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_RELEASE: begin
                if (r_cnt == GAP_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Key code to matrix position; row 3 carries *, 0, #, D.
    always_comb begin
        w_row_idx = 2'd0;
        w_col_idx = 2'd0;
        case (r_key)
            4'd1:  begin w_row_idx = 2'd0; w_col_idx = 2'd0; end
            4'd2:  begin w_row_idx = 2'd0; w_col_idx = 2'd1; end
            4'd3:  begin w_row_idx = 2'd0; w_col_idx = 2'd2; end
            4'd10: begin w_row_idx = 2'd0; w_col_idx = 2'd3; end
            4'd4:  begin w_row_idx = 2'd1; w_col_idx = 2'd0; end
            4'd5:  begin w_row_idx = 2'd1; w_col_idx = 2'd1; end
            4'd6:  begin w_row_idx = 2'd1; w_col_idx = 2'd2; end
            4'd11: begin w_row_idx = 2'd1; w_col_idx = 2'd3; end
            4'd7:  begin w_row_idx = 2'd2; w_col_idx = 2'd0; end
            4'd8:  begin w_row_idx = 2'd2; w_col_idx = 2'd1; end
            4'd9:  begin w_row_idx = 2'd2; w_col_idx = 2'd2; end
            4'd12: begin w_row_idx = 2'd2; w_col_idx = 2'd3; end
            4'd14: begin w_row_idx = 2'd3; w_col_idx = 2'd0; end
            4'd0:  begin w_row_idx = 2'd3; w_col_idx = 2'd1; end
            4'd15: begin w_row_idx = 2'd3; w_col_idx = 2'd2; end
            default: begin w_row_idx = 2'd3; w_col_idx = 2'd3; end  // 13 = D
        endcase
    end

`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam logic [CNT_W-1:0] BOUNCE_LIM = CNT_W'(BOUNCE_TICKS);

    logic [15:0] r_lfsr;
    logic        w_in_bounce;

    // Free-running Fibonacci LFSR, taps 16,14,13,11, supplies the bounce pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    assign w_in_bounce = (r_state != S_IDLE) && (r_cnt < BOUNCE_LIM);
    assign w_pressed   = w_in_bounce ? r_lfsr[0] : (r_state == S_PRESS);
`else
    assign w_pressed = (r_state == S_PRESS);
`endif

    // Column drive: clear the key's column bit only while its row is strobed.
    always_comb begin
        w_col_nxt = 4'hF;
        if (w_pressed && !kp_bus.row[2'd3 - w_row_idx]) begin
            w_col_nxt[w_col_idx] = 1'b0;
        end
    end

    assign kp_bus.key_ready = (r_state == S_IDLE);
    assign kp_bus.col       = r_col;
    assign kp_bus.busy      = r_busy;
    assign kp_bus.done      = r_done;
    assign kp_bus.dbg_state = r_state;

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: directed scenarios plus randomized requests and
// row strobes, scored against a cycle-indexed reference model of the keypad.
// Build with KEYPAD_EMU_BOUNCE_EN to include the bounce behaviour in the model.
module tb_keypad_emulator;
  localparam int HOLD   = 50;
  localparam int GAP    = 20;
  localparam int BOUNCE = 8;
  localparam int TXN    = HOLD + GAP;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_emulator_if kp ();

  keypad_emulator #(
    .HOLD_TICKS  (HOLD),
    .GAP_TICKS   (GAP),
    .CNT_W       (24),
    .BOUNCE_TICKS(BOUNCE)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .kp_bus(kp.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;   // rising edges seen; at a falling edge it names the current cycle

  // ---------------- reference model ----------------
  int layout [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};
  logic [6:0]  exp_q[$];   // {col, busy, done, ready} expected after each edge
  int          done_q[$];  // cycle in which each accepted request must finish
  bit          m_active = 1'b0;
  int          k_acc    = 0;
  logic [3:0]  m_key    = 4'd0;
  int          acc_cnt  = 0;
  logic [15:0] m_lfsr   = 16'hACE1;

  function automatic void key_pos(input logic [3:0] key, output int r, output int c);
    r = 0;
    c = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (layout[i][j] == int'(key)) begin
          r = i;
          c = j;
        end
  endfunction

  function automatic bit in_win(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // True when the keypad should be idle in the current cycle.
  function automatic bit m_idle_now();
    return !(m_active && in_win(cyc, k_acc, k_acc + TXN - 1));
  endfunction

  always @(posedge clk) begin : model
    int   k, r, c;
    bit   idle_b, pressed_b, busy_a, done_a;
    logic [3:0] ecol;
    cyc = cyc + 1;
    k   = cyc;
    if (rst) begin
      m_active = 1'b0;
      m_lfsr   = 16'hACE1;
      exp_q.delete();
      done_q.delete();
    end else begin
      // Cycle k-1 is the one ending at this edge.
      idle_b    = !(m_active && in_win(k - 1, k_acc, k_acc + TXN - 1));
      pressed_b = m_active && in_win(k - 1, k_acc, k_acc + HOLD - 1);
`ifdef KEYPAD_EMU_BOUNCE_EN
      if (m_active && (in_win(k - 1, k_acc, k_acc + BOUNCE - 1) ||
                       in_win(k - 1, k_acc + HOLD, k_acc + HOLD + BOUNCE - 1)))
        pressed_b = m_lfsr[0];
`endif
      ecol = 4'hF;
      if (pressed_b) begin
        key_pos(m_key, r, c);
        if (kp.row[3 - r] == 1'b0) ecol[c] = 1'b0;
      end
      done_a = m_active && (k == k_acc + TXN);
      if (idle_b && kp.key_valid) begin
        k_acc    = k;
        m_key    = kp.key_in;
        m_active = 1'b1;
        done_q.push_back(k + TXN);
        acc_cnt  = acc_cnt + 1;
      end
      busy_a = m_active && in_win(k, k_acc, k_acc + TXN - 1);
      exp_q.push_back({ecol, busy_a, done_a, !busy_a});
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin : monitor
    logic [6:0] e, got;
    int d;
    if (!rst && exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {kp.col, kp.busy, kp.done, kp.key_ready};
      checks = checks + 1;
      if (got !== e) begin
        errors = errors + 1;
        $display("FAIL outputs cyc=%0d: got col=%b busy=%b done=%b ready=%b, expected col=%b busy=%b done=%b ready=%b",
                 cyc, got[6:3], got[2], got[1], got[0], e[6:3], e[2], e[1], e[0]);
      end
    end
    if (!rst && kp.done === 1'b1) begin
      checks = checks + 1;
      if (done_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL done_spurious cyc=%0d: got done=1, expected no pending request", cyc);
      end else begin
        d = done_q.pop_front();
        if (d != cyc) begin
          errors = errors + 1;
          $display("FAIL done_time: got done in cycle %0d, expected cycle %0d", cyc, d);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [3:0] rand_row();
    logic [3:0] one;
    one = 4'b0001;
    case ($urandom_range(0, 3))
      0, 1:    return ~(one << $urandom_range(0, 3));
      2:       return 4'($urandom_range(0, 15));
      default: return 4'hF;
    endcase
  endfunction

  // Offer a key and hold key_valid until the request is taken.
  task automatic press(input logic [3:0] key);
    int a, n;
    a = acc_cnt;
    n = 0;
    kp.key_in    = key;
    kp.key_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (acc_cnt == a && n < 300);
    kp.key_valid = 1'b0;
    if (acc_cnt == a) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL accept_timeout: got no accept of key %0d in %0d cycles, expected one", key, n);
    end
  endtask

  // Run until idle; with noise, strobe random rows and offer requests that must be ignored.
  task automatic run_until_idle(input bit noise);
    int n;
    n = 0;
    while (!m_idle_now() && n < 500) begin
      @(negedge clk);
      n++;
      if (noise) kp.row = rand_row();
      if (noise && !m_idle_now()) begin
        kp.key_valid = ($urandom_range(0, 3) == 0);
        kp.key_in    = 4'($urandom_range(0, 15));
      end else begin
        kp.key_valid = 1'b0;
      end
    end
    kp.key_valid = 1'b0;
    if (!m_idle_now()) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL idle_timeout: got busy after %0d cycles, expected idle", n);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int a, n;
    kp.key_in    = 4'd0;
    kp.key_valid = 1'b0;
    kp.row       = 4'hF;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_col",   16'(kp.col),       16'hF);
    check("rst_ready", 16'(kp.key_ready), 16'h1);
    check("rst_busy",  16'(kp.busy),      16'h0);
    check("rst_done",  16'(kp.done),      16'h0);
    check("rst_state", 16'(kp.dbg_state), 16'h0);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);

    // Key 5 on row 1: row-select patterns, including several rows low
    kp.row = 4'b1011;
    press(4'd5);
    repeat (4) @(negedge clk);
    kp.row = 4'b0111;
    repeat (3) @(negedge clk);
    kp.row = 4'b0000;
    repeat (3) @(negedge clk);
    kp.row = 4'b1111;
    repeat (3) @(negedge clk);
    kp.row = 4'b1011;
    run_until_idle(1'b0);

    // Key 14 with key_valid held high; second key must go in on the done cycle
    repeat (2) @(negedge clk);
    kp.row       = 4'b1110;
    kp.key_in    = 4'd14;
    kp.key_valid = 1'b1;
    a = acc_cnt;
    n = 0;
    do begin @(negedge clk); n++; end while (acc_cnt == a && n < 300);
    kp.key_in = 4'd7;
    a = acc_cnt;
    n = 0;
    do begin @(negedge clk); n++; end while (acc_cnt == a && n < 300);
    kp.key_valid = 1'b0;
    kp.row       = 4'b1101;
    run_until_idle(1'b0);

    // Key 1 with row 0 strobed (bounce visible on col[0] when enabled)
    kp.row = 4'b0111;
    press(4'd1);
    run_until_idle(1'b0);

    // Randomized requests, row strobes and ignored requests while busy
    for (int t = 0; t < 10; t++) begin
      repeat ($urandom_range(0, 4)) begin
        @(negedge clk);
        kp.row = rand_row();
      end
      kp.row = rand_row();
      press(4'($urandom_range(0, 15)));
      run_until_idle(1'b1);
    end

    // Asynchronous reset in the middle of a press of D
    kp.row = 4'b1110;
    press(4'd13);
    repeat (25) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_col",   16'(kp.col),       16'hF);
    check("arst_busy",  16'(kp.busy),      16'h0);
    check("arst_done",  16'(kp.done),      16'h0);
    check("arst_state", 16'(kp.dbg_state), 16'h0);
    check("arst_ready", 16'(kp.key_ready), 16'h1);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (TXN + 10) @(negedge clk);

    // One last request after reset to show the keypad is usable again
    kp.row = 4'b0111;
    press(4'd10);
    run_until_idle(1'b0);
    repeat (3) @(negedge clk);

    check("done_pending", 16'(done_q.size()), 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Overall time bound
  initial begin : watchdog
    #2_000_000;
    errors = errors + 1;
    $display("FAIL watchdog: got no completion by %0t, expected earlier finish", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
